// File: rtl/ibis_pixel_fifo.sv
// ibis_pixel_fifo
// ---------------------------------------------------------------------------
// Pixel elasticity buffer between the framebuffer reader (AXI-Stream style
// input) and the three TMDS channel encoders. Pixels are released one per
// active-video cycle of the display timing generator. The timing signals are
// delayed by one register stage, so the encoders see sync, blank and data
// aligned on the same cycle.
//
// Underflow (FIFO empty during active video) and frame misalignment (the
// start-of-frame beat does not line up with in_sof) force UNDERFLOW_RGB onto
// active video, set a sticky flag and flush the FIFO. Output resynchronises
// on the next frame whose first beat carries tuser.
//
// Optional feature, macro IBIS_PIXEL_FIFO_STATS_EN: adds a saturating 16-bit
// underflow_count output that counts every cycle raising an underflow event.
//
// Ports:
//   aclk, areset          pixel clock, synchronous active-high reset
//   enable                clock enable; low freezes all state, s_tready=0
//   s_tdata/s_tuser/...   pixel input stream {R,G,B}, tuser = first of frame
//   s_tlast               end of line marker, not used by the core logic
//   in_de/hsync/vsync/sof timing generator inputs
//   out_de/hsync/vsync    timing delayed by one cycle
//   out_red/grn/blu       pixel data, zero outside active video
//   underflow             sticky error flag, cleared only by reset
//   level                 current FIFO occupancy
//   underflow_count       (IBIS_PIXEL_FIFO_STATS_EN only) event counter
//
// Handshake: a beat transfers on every rising edge where s_tvalid and
// s_tready are both high. s_tready depends only on enable, reset, the state
// and the registered level (never on s_tvalid or on a same-cycle pop), and
// s_tvalid/s_tdata/s_tuser must be held stable until the transfer.
// ---------------------------------------------------------------------------
module ibis_pixel_fifo #(
  parameter int unsigned DEPTH         = 1024,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      enable,
  input  logic [23:0]               s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tuser,
  input  logic                      s_tlast,
  input  logic                      in_de,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
  input  logic                      in_sof,
  output logic                      out_de,
  output logic                      out_hsync,
  output logic                      out_vsync,
  output logic [7:0]                out_red,
  output logic [7:0]                out_grn,
  output logic [7:0]                out_blu,
  output logic                      underflow,
  output logic [$clog2(DEPTH):0]    level
`ifdef IBIS_PIXEL_FIFO_STATS_EN
  ,
  output logic [15:0]               underflow_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // FLUSH: discard until a tuser beat; ARMED: buffering, wait for in_sof;
  // STREAM: one pop per active-video cycle.
  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_ARMED  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_addr;
  logic [24:0]   head;
  logic          full;
  logic          push;
  logic          store;
  logic          pop;
  logic          flush;
  logic          uf_event;
  logic [23:0]   rgb_d;
  logic          unused_tlast;

  // Line markers are not needed: alignment is checked at frame granularity.
  assign unused_tlast = s_tlast;

  assign head = mem[rd_q];
  assign full = (level == LW'(DEPTH));

  // In FLUSH the old contents are being thrown away, so the input is never
  // back-pressured there even if the registered level still reads full.
  assign s_tready = enable && !areset && ((state_q == ST_FLUSH) || !full);
  assign push     = s_tvalid && s_tready;

  // Next state, pop/store decisions and the pixel value for the output stage.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    flush    = 1'b0;
    uf_event = 1'b0;
    store    = push;
    rgb_d    = underflow ? UNDERFLOW_RGB : 24'h0;
    unique case (state_q)
      ST_FLUSH: begin
        flush = 1'b1;
        store = push && s_tuser;
        if (store) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (in_sof) begin
          if (level == '0) begin
            uf_event = 1'b1;
          end else if (head[24]) begin
            pop     = 1'b1;
            rgb_d   = head[23:0];
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (in_de) begin
          if (level == '0) begin
            uf_event = 1'b1;
            rgb_d    = UNDERFLOW_RGB;
            state_d  = ST_FLUSH;
          end else begin
            pop = 1'b1;
            // A frame start must pop exactly on in_sof, and in_sof must pop
            // a frame start; anything else means reader and display drifted.
            if (head[24] != in_sof) begin
              uf_event = 1'b1;
              rgb_d    = UNDERFLOW_RGB;
              state_d  = ST_FLUSH;
            end else begin
              rgb_d = head[23:0];
            end
          end
        end
      end
      default: state_d = ST_FLUSH;
    endcase
    if (!in_de) rgb_d = 24'h0;
  end

  // The tuser beat that leaves FLUSH lands at address 0 since the pointers
  // are being cleared in the same cycle.
  assign wr_addr = flush ? '0 : wr_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_FLUSH;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (store) mem[wr_addr] <= {s_tuser, s_tdata};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      level     <= '0;
      underflow <= 1'b0;
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
      out_red   <= 8'h0;
      out_grn   <= 8'h0;
      out_blu   <= 8'h0;
    end else if (enable) begin
      if (flush) begin
        rd_q  <= '0;
        wr_q  <= store ? AW'(1) : '0;
        level <= store ? LW'(1) : '0;
      end else begin
        if (store) wr_q <= wr_q + AW'(1);
        if (pop)   rd_q <= rd_q + AW'(1);
        unique case ({store, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
      if (uf_event) underflow <= 1'b1;
      out_de    <= in_de;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      out_red   <= rgb_d[23:16];
      out_grn   <= rgb_d[15:8];
      out_blu   <= rgb_d[7:0];
    end
  end

`ifdef IBIS_PIXEL_FIFO_STATS_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      underflow_count <= 16'h0;
    end else if (enable && uf_event && (underflow_count != 16'hFFFF)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule
